// File: rtl/spi_xfer_queue.sv
// rtl/spi_xfer_queue.sv - TX/RX word queues feeding an SPI master's start/ready/done handshake
// Launches one master transfer per queued TX word and captures each received word for the host.
module spi_xfer_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DATA_WIDTH-1:0]       rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] tx_count,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic [15:0]                 xfer_cnt,
  output logic                        busy,
  input  logic                        spi_ready,
  input  logic                        spi_done,
  input  logic [DATA_WIDTH-1:0]       spi_rcv_data,
  output logic                        spi_start,
  output logic [DATA_WIDTH-1:0]       spi_snd_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH   = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_e;

  state_e                state_q, state_d;
  logic                  spi_start_q, spi_start_d;
  logic [DATA_WIDTH-1:0] spi_snd_data_q, spi_snd_data_d;
  logic [15:0]           xfer_cnt_q, xfer_cnt_d;
  logic [AW:0]           tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW:0]           rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] tx_mem_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_d [FIFO_DEPTH];
  logic                  tx_push;
  logic                  rx_pop;

  // Pointers carry an extra wrap bit, so full and empty are distinguishable by subtraction.
  assign tx_count     = tx_wr_q - tx_rd_q;
  assign rx_count     = rx_wr_q - rx_rd_q;
  assign tx_ready     = (tx_count != DEPTH);
  assign rx_valid     = (rx_count != '0);
  assign rx_data      = rx_mem_q[rx_rd_q[AW-1:0]];
  assign tx_push      = tx_valid && tx_ready;
  assign rx_pop       = rx_valid && rx_ready;
  assign busy         = (state_q != S_IDLE) || (tx_count != '0);
  assign spi_start    = spi_start_q;
  assign spi_snd_data = spi_snd_data_q;
  assign xfer_cnt     = xfer_cnt_q;

  always_comb begin
    state_d        = state_q;
    spi_start_d    = 1'b0;
    spi_snd_data_d = spi_snd_data_q;
    xfer_cnt_d     = xfer_cnt_q;
    tx_wr_d        = tx_wr_q;
    tx_rd_d        = tx_rd_q;
    rx_wr_d        = rx_wr_q;
    rx_rd_d        = rx_rd_q;
    tx_mem_d       = tx_mem_q;
    rx_mem_d       = rx_mem_q;

    if (tx_push) begin
      tx_mem_d[tx_wr_q[AW-1:0]] = tx_data;
      tx_wr_d                   = tx_wr_q + PTR_ONE;
    end

    case (state_q)
      // Requiring a free RX slot at launch guarantees the received word always has room.
      S_IDLE: begin
        if ((tx_count != '0) && (rx_count < DEPTH) && spi_ready) begin
          spi_snd_data_d = tx_mem_q[tx_rd_q[AW-1:0]];
          tx_rd_d        = tx_rd_q + PTR_ONE;
          spi_start_d    = 1'b1;
          state_d        = S_START;
        end
      end
      S_START: state_d = S_BUSY;
      S_BUSY: begin
        if (spi_done) begin
          rx_mem_d[rx_wr_q[AW-1:0]] = spi_rcv_data;
          rx_wr_d                   = rx_wr_q + PTR_ONE;
          xfer_cnt_d                = xfer_cnt_q + 16'd1;
          state_d                   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rx_pop) begin
      rx_rd_d = rx_rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      spi_start_q    <= 1'b0;
      spi_snd_data_q <= '0;
      xfer_cnt_q     <= '0;
      tx_wr_q        <= '0;
      tx_rd_q        <= '0;
      rx_wr_q        <= '0;
      rx_rd_q        <= '0;
      tx_mem_q       <= '{default: '0};
      rx_mem_q       <= '{default: '0};
    end else begin
      state_q        <= state_d;
      spi_start_q    <= spi_start_d;
      spi_snd_data_q <= spi_snd_data_d;
      xfer_cnt_q     <= xfer_cnt_d;
      tx_wr_q        <= tx_wr_d;
      tx_rd_q        <= tx_rd_d;
      rx_wr_q        <= rx_wr_d;
      rx_rd_q        <= rx_rd_d;
      tx_mem_q       <= tx_mem_d;
      rx_mem_q       <= rx_mem_d;
    end
  end

endmodule
